// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame states, mode codes, mode bit positions.
// No ports; imported by spi_clk_div and spi_master_engine.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        XFER  = 2'd2,
        TRAIL = 2'd3
    } spi_state_e;

    // SelectMode encodings: {CPOL, CPHA}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    localparam int CPOL_BIT = 1;
    localparam int CPHA_BIT = 0;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: Tick_o pulses every CLK_DIV enabled cycles.
// Ports: clk, Reset (async high), En_i (count), Clr_i (sync clear), Tick_o.
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic Reset,
    input  logic En_i,
    input  logic Clr_i,
    output logic Tick_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Tick must not depend on Clr_i: the FSM derives the clear from
    // its next state, which itself depends on the tick.
    assign Tick_o = En_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (Clr_i) begin
            cnt_d = '0;
        end else if (En_i) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master_engine.sv
// SPI master frame engine: CS_n framing, divided SCLK, MSB-first shifting, all 4 modes.
// Ports: clk, Reset, Start, SelectMode, Tx_Data, MISO -> SCLK, MOSI, CS_n, Count_Enable, Busy, Done, Rx_Data.
module spi_master_engine
    import spi_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [1:0]        SelectMode,
    input  logic [DATA_W-1:0] Tx_Data,
    input  logic              MISO,
    output logic              SCLK,
    output logic              MOSI,
    output logic              CS_n,
    output logic              Count_Enable,
    output logic              Busy,
    output logic              Done,
    output logic [DATA_W-1:0] Rx_Data
);

    localparam int EW = $clog2(2 * DATA_W);
    localparam logic [EW-1:0] EDGE_LAST = EW'(2 * DATA_W - 1);

    spi_state_e        state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rxs_q, rxs_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [EW-1:0]     edge_q, edge_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              done_q, done_d;

    logic tick;
    logic clr;
    logic lead;
    logic last;
    logic sample;

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk    (clk),
        .Reset  (Reset),
        .En_i   (state_q != IDLE),
        .Clr_i  (clr),
        .Tick_o (tick)
    );

    // Even edge indices are leading edges; the sampling edge is the
    // leading one for CPHA=0 and the trailing one for CPHA=1.
    assign lead   = ~edge_q[0];
    assign last   = (edge_q == EDGE_LAST);
    assign sample = lead ^ mode_q[CPHA_BIT];

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        tx_d    = tx_q;
        rxs_d   = rxs_q;
        rx_d    = rx_q;
        edge_d  = edge_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                sclk_d = mode_q[CPOL_BIT];
                if (Start) begin
                    state_d = LEAD;
                    mode_d  = SelectMode;
                    sclk_d  = SelectMode[CPOL_BIT];
                    rxs_d   = '0;
                    edge_d  = '0;
                    if (!SelectMode[CPHA_BIT]) begin
                        // First bit must be valid before the first edge.
                        mosi_d = Tx_Data[DATA_W-1];
                        tx_d   = {Tx_Data[DATA_W-2:0], 1'b0};
                    end else begin
                        mosi_d = 1'b0;
                        tx_d   = Tx_Data;
                    end
                end
            end
            LEAD: begin
                sclk_d = mode_q[CPOL_BIT];
                if (tick) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                if (tick) begin
                    sclk_d = ~sclk_q;
                    edge_d = edge_q + 1'b1;
                    if (sample) begin
                        rxs_d = {rxs_q[DATA_W-2:0], MISO};
                    end else if (!last) begin
                        mosi_d = tx_q[DATA_W-1];
                        tx_d   = {tx_q[DATA_W-2:0], 1'b0};
                    end
                    if (last) begin
                        state_d = TRAIL;
                        edge_d  = '0;
                    end
                end
            end
            TRAIL: begin
                sclk_d = mode_q[CPOL_BIT];
                if (tick) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    mosi_d  = 1'b0;
                    rx_d    = rxs_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Each phase starts its divider from zero.
    assign clr = (state_d != state_q);

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            mode_q  <= MODE0;
            tx_q    <= '0;
            rxs_q   <= '0;
            rx_q    <= '0;
            edge_q  <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            tx_q    <= tx_d;
            rxs_q   <= rxs_d;
            rx_q    <= rx_d;
            edge_q  <= edge_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            done_q  <= done_d;
        end
    end

    assign SCLK         = sclk_q;
    assign MOSI         = mosi_q;
    assign CS_n         = (state_q == IDLE);
    assign Count_Enable = (state_q != IDLE);
    assign Busy         = (state_q != IDLE);
    assign Done         = done_q;
    assign Rx_Data      = rx_q;

endmodule
